// File: rtl/hwpe_multi_ctrl_router.sv
// Control front-end for an N-engine HWPE cluster: routes the periph port to engines, serves local CSRs
// and switches the static TCDM mux only after in-flight reads of the active engine have drained.
module hwpe_multi_ctrl_router #(
  parameter int unsigned NrHwpe     = 4,
  parameter int unsigned NrCores    = 2,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned IdWidth    = 2,
  parameter int unsigned HwpeSelLsb = 8,
  parameter int unsigned OutstW     = 4,
  localparam int unsigned SelW      = $clog2(NrHwpe)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          ctrl_q_valid_i,
  output logic                          ctrl_q_ready_o,
  input  logic [AddrWidth-1:0]          ctrl_q_addr_i,
  input  logic                          ctrl_q_write_i,
  input  logic [DataWidth-1:0]          ctrl_q_data_i,
  input  logic [DataWidth/8-1:0]        ctrl_q_strb_i,
  input  logic [IdWidth-1:0]            ctrl_q_user_i,
  output logic                          ctrl_p_valid_o,
  output logic [DataWidth-1:0]          ctrl_p_data_o,
  output logic [NrHwpe-1:0]             hwpe_req_o,
  input  logic [NrHwpe-1:0]             hwpe_gnt_i,
  output logic [AddrWidth-1:0]          hwpe_add_o,
  output logic                          hwpe_wen_o,
  output logic [DataWidth/8-1:0]        hwpe_be_o,
  output logic [DataWidth-1:0]          hwpe_data_o,
  output logic [IdWidth-1:0]            hwpe_id_o,
  input  logic [NrHwpe-1:0]             hwpe_r_valid_i,
  input  logic [NrHwpe*DataWidth-1:0]   hwpe_r_data_i,
  input  logic                          tcdm_req_i,
  input  logic                          tcdm_gnt_i,
  input  logic                          tcdm_r_valid_i,
  output logic                          tcdm_hold_o,
  output logic [SelW-1:0]               mux_sel_o,
  output logic [NrHwpe-1:0]             clk_en_o,
  input  logic [NrHwpe*NrCores-1:0]     evt_i,
  output logic [NrCores-1:0]            evt_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StSwitch = 2'd2;

  localparam logic [HwpeSelLsb-1:0] OffClkEn  = HwpeSelLsb'(8'h00);
  localparam logic [HwpeSelLsb-1:0] OffMuxSel = HwpeSelLsb'(8'h04);
  localparam logic [HwpeSelLsb-1:0] OffEvt    = HwpeSelLsb'(8'h08);
  localparam logic [HwpeSelLsb-1:0] OffStatus = HwpeSelLsb'(8'h0C);

  logic [SelW-1:0]       sel, tgt_q, target_q, target_d, mux_sel_q;
  logic                  is_local, sel_ok, local_acc, hs, csr_we, sel_wr_ok;
  logic                  pending_q, tgt_local_q, rsp_vld_q;
  logic [DataWidth-1:0]  rsp_data_q, rdata_local, eng_rdata, wmask, sel_merged;
  logic                  gnt_sel, eng_rvalid;
  logic [NrHwpe-1:0]     clk_en_q;
  logic [NrCores-1:0]    evt_q, evt_set, evt_clr;
  logic [1:0]            state_q, state_d;
  logic [OutstW-1:0]     out_cnt_q;
  logic                  cnt_inc, cnt_dec;
  logic [HwpeSelLsb-1:0] offset;
  logic                  unused_addr;

  assign sel       = ctrl_q_addr_i[HwpeSelLsb +: SelW];
  assign is_local  = ctrl_q_addr_i[HwpeSelLsb+SelW];
  assign sel_ok    = 32'(sel) < NrHwpe;
  assign local_acc = is_local | ~sel_ok;
  assign offset    = ctrl_q_addr_i[HwpeSelLsb-1:0];
  assign unused_addr = ^ctrl_q_addr_i[AddrWidth-1:HwpeSelLsb+SelW+1];

  always_comb begin
    gnt_sel    = 1'b0;
    eng_rvalid = 1'b0;
    eng_rdata  = '0;
    hwpe_req_o = '0;
    for (int i = 0; i < NrHwpe; i++) begin
      if (sel == SelW'(i)) begin
        gnt_sel       = hwpe_gnt_i[i];
        hwpe_req_o[i] = ctrl_q_valid_i & ~pending_q & ~local_acc;
      end
      if (tgt_q == SelW'(i)) begin
        eng_rvalid = hwpe_r_valid_i[i];
        eng_rdata  = hwpe_r_data_i[i*DataWidth +: DataWidth];
      end
    end
  end

  assign hwpe_add_o  = {{(AddrWidth-HwpeSelLsb){1'b0}}, ctrl_q_addr_i[HwpeSelLsb-1:0]};
  assign hwpe_wen_o  = ~ctrl_q_write_i;
  assign hwpe_be_o   = ctrl_q_strb_i;
  assign hwpe_data_o = ctrl_q_data_i;
  assign hwpe_id_o   = ctrl_q_user_i;

  assign ctrl_q_ready_o = ~pending_q & (local_acc ? ctrl_q_valid_i : gnt_sel);
  assign hs             = ctrl_q_valid_i & ctrl_q_ready_o;
  // Engine responses bypass straight through; local ones come from the response register.
  assign ctrl_p_valid_o = rsp_vld_q | (pending_q & ~tgt_local_q & eng_rvalid);
  assign ctrl_p_data_o  = (pending_q & ~tgt_local_q) ? eng_rdata : rsp_data_q;

  always_comb begin
    wmask = '0;
    for (int b = 0; b < DataWidth/8; b++) wmask[b*8 +: 8] = {8{ctrl_q_strb_i[b]}};
  end

  assign csr_we     = hs & ctrl_q_write_i & is_local;
  assign sel_merged = (DataWidth'(target_q) & ~wmask) | (ctrl_q_data_i & wmask);
  assign sel_wr_ok  = csr_we & (offset == OffMuxSel) & (sel_merged < DataWidth'(NrHwpe));
  assign target_d   = sel_wr_ok ? sel_merged[SelW-1:0] : target_q;
  assign evt_clr    = (csr_we && offset == OffEvt) ?
                      (ctrl_q_data_i[NrCores-1:0] & wmask[NrCores-1:0]) : '0;

  always_comb begin
    evt_set = '0;
    for (int i = 0; i < NrHwpe; i++)
      for (int c = 0; c < NrCores; c++)
        evt_set[c] = evt_set[c] | (evt_i[i*NrCores+c] & clk_en_q[i]);
  end

  always_comb begin
    rdata_local = '0;
    if (is_local && !ctrl_q_write_i) begin
      case (offset)
        OffClkEn:  rdata_local = DataWidth'(clk_en_q);
        OffMuxSel: rdata_local = DataWidth'(target_q);
        OffEvt:    rdata_local = DataWidth'(evt_q);
        OffStatus: rdata_local = DataWidth'({target_q != mux_sel_q, state_q == StDrain, mux_sel_q});
        default:   rdata_local = '0;
      endcase
    end
  end

  assign cnt_inc = tcdm_req_i & tcdm_gnt_i;
  assign cnt_dec = tcdm_r_valid_i;

  // A grant in the drain cycle means a new read is being issued, so the switch waits one more cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (target_d != mux_sel_q) state_d = StDrain;
      StDrain: begin
        if (target_d == mux_sel_q)             state_d = StIdle;
        else if (out_cnt_q == '0 && !cnt_inc)  state_d = StSwitch;
      end
      StSwitch: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  assign tcdm_hold_o = (state_q == StDrain) || (state_q == StSwitch);
  assign mux_sel_o   = mux_sel_q;
  assign clk_en_o    = clk_en_q;
  assign evt_o       = evt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q   <= 1'b0;
      tgt_local_q <= 1'b0;
      tgt_q       <= '0;
      rsp_vld_q   <= 1'b0;
      rsp_data_q  <= '0;
      clk_en_q    <= '0;
      target_q    <= '0;
      mux_sel_q   <= '0;
      evt_q       <= '0;
      state_q     <= StIdle;
      out_cnt_q   <= '0;
    end else begin
      if (ctrl_p_valid_o) pending_q <= 1'b0;
      else if (hs)        pending_q <= 1'b1;
      if (hs) begin
        tgt_local_q <= local_acc;
        tgt_q       <= sel;
      end
      rsp_vld_q <= hs & local_acc;
      if (hs && local_acc) rsp_data_q <= rdata_local;
      if (csr_we && offset == OffClkEn)
        clk_en_q <= (clk_en_q & ~wmask[NrHwpe-1:0]) | (ctrl_q_data_i[NrHwpe-1:0] & wmask[NrHwpe-1:0]);
      target_q <= target_d;
      evt_q    <= (evt_q & ~evt_clr) | evt_set;
      state_q  <= state_d;
      if (state_q == StSwitch) mux_sel_q <= target_q;
      if (cnt_inc && !cnt_dec && out_cnt_q != '1)       out_cnt_q <= out_cnt_q + 1'b1;
      else if (cnt_dec && !cnt_inc && out_cnt_q != '0)  out_cnt_q <= out_cnt_q - 1'b1;
    end
  end

  a_cnt_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(cnt_inc && !cnt_dec && (&out_cnt_q)));
  a_cnt_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(cnt_dec && !cnt_inc && out_cnt_q == '0));

endmodule

// File: tb/tb_hwpe_multi_ctrl_router.sv
// Directed bench for hwpe_multi_ctrl_router: a scoreboard queue of expected periph responses
// is drained by a monitor while the stimulus process also checks CSR side effects.
module tb_hwpe_multi_ctrl_router;
  localparam int NH = 4;
  localparam int NC = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic              q_valid, q_ready, q_write, p_valid;
  logic [31:0]       q_addr, q_data, p_data;
  logic [3:0]        q_strb;
  logic [1:0]        q_user;
  logic [NH-1:0]     h_req, h_gnt, h_rvalid, clk_en;
  logic [31:0]       h_add, h_data;
  logic              h_wen;
  logic [3:0]        h_be;
  logic [1:0]        h_id, mux_sel;
  logic [NH*DW-1:0]  h_rdata;
  logic              t_req, t_gnt, t_rvalid, t_hold;
  logic [NH*NC-1:0]  evt_in;
  logic [NC-1:0]     evt_out;

  hwpe_multi_ctrl_router dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ctrl_q_valid_i(q_valid), .ctrl_q_ready_o(q_ready), .ctrl_q_addr_i(q_addr),
    .ctrl_q_write_i(q_write), .ctrl_q_data_i(q_data), .ctrl_q_strb_i(q_strb),
    .ctrl_q_user_i(q_user), .ctrl_p_valid_o(p_valid), .ctrl_p_data_o(p_data),
    .hwpe_req_o(h_req), .hwpe_gnt_i(h_gnt), .hwpe_add_o(h_add), .hwpe_wen_o(h_wen),
    .hwpe_be_o(h_be), .hwpe_data_o(h_data), .hwpe_id_o(h_id),
    .hwpe_r_valid_i(h_rvalid), .hwpe_r_data_i(h_rdata),
    .tcdm_req_i(t_req), .tcdm_gnt_i(t_gnt), .tcdm_r_valid_i(t_rvalid),
    .tcdm_hold_o(t_hold), .mux_sel_o(mux_sel), .clk_en_o(clk_en),
    .evt_i(evt_in), .evt_o(evt_out)
  );

  typedef struct packed {
    logic        chk;
    logic        loc;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic csr(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input logic [NH*NC-1:0] evt,
                     input logic [31:0] exp, output int waits);
    exp_t e;
    @(posedge clk); #1;
    q_valid = 1'b1; q_addr = addr; q_write = wr; q_data = wdata; q_strb = strb; evt_in = evt;
    waits = 0;
    @(negedge clk);
    while (!q_ready && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    if (!q_ready) check("csr_ready_timeout", 32'(q_ready), 32'd1);
    else begin
      e.chk = ~wr; e.loc = 1'b1; e.data = exp; e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    q_valid = 1'b0; evt_in = '0;
  endtask

  task automatic eng_acc(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int idx, input int dly, input logic [31:0] rdata);
    exp_t e;
    @(posedge clk); #1;
    q_valid = 1'b1; q_addr = addr; q_write = wr; q_data = wdata; q_strb = 4'hF; q_user = 2'b01;
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      check("eng_req_wait", 32'(h_req), 32'(1 << idx));
      check("eng_ready_wait", 32'(q_ready), 32'd0);
      @(posedge clk); #1;
    end
    h_gnt[idx] = 1'b1;
    @(negedge clk);
    check("eng_ready_gnt", 32'(q_ready), 32'd1);
    check("eng_add", h_add, {24'd0, addr[7:0]});
    check("eng_wen", 32'(h_wen), 32'(!wr));
    check("eng_id", 32'(h_id), 32'd1);
    if (wr) check("eng_wdata", h_data, wdata);
    e.chk = ~wr; e.loc = 1'b0; e.data = rdata; e.cyc = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    q_valid = 1'b0; h_gnt = '0;
    h_rvalid[idx] = 1'b1; h_rdata[idx*DW +: DW] = rdata;
    @(posedge clk); #1;
    h_rvalid = '0;
  endtask

  task automatic tcdm_reads(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      t_req = 1'b1; t_gnt = 1'b1;
    end
    @(posedge clk); #1;
    t_req = 1'b0; t_gnt = 1'b0;
  endtask

  task automatic rvalid_pulse();
    @(posedge clk); #1; t_rvalid = 1'b1;
    @(posedge clk); #1; t_rvalid = 1'b0;
  endtask

  task automatic evt_pulse(input logic [NH*NC-1:0] v);
    @(posedge clk); #1; evt_in = v;
    @(posedge clk); #1; evt_in = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int w;
    exp_t e;
    q_valid = 0; q_addr = 0; q_write = 0; q_data = 0; q_strb = 0; q_user = 0;
    h_gnt = 0; h_rvalid = 0; h_rdata = '0; t_req = 0; t_gnt = 0; t_rvalid = 0; evt_in = 0;

    fork
      forever begin
        @(negedge clk);
        if (rst_ni && p_valid) begin
          if (sb.size() == 0) check("rsp_unexpected", 32'(p_valid), 32'd0);
          else begin
            e = sb.pop_front();
            if (e.chk) check("rsp_data", p_data, e.data);
            if (e.loc) check("rsp_latency", cyc, e.cyc + 1);
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    check("rst_q_ready", 32'(q_ready), 0);
    check("rst_p_valid", 32'(p_valid), 0);
    check("rst_p_data", p_data, 0);
    check("rst_hwpe_req", 32'(h_req), 0);
    check("rst_hold", 32'(t_hold), 0);
    check("rst_mux_sel", 32'(mux_sel), 0);
    check("rst_clk_en", 32'(clk_en), 0);
    check("rst_evt", 32'(evt_out), 0);
    @(posedge clk); #1 rst_ni = 1'b1;

    csr(0, 32'h40C, 0, 4'hF, 0, 32'h0, w);
    check("csr_ready_immediate", 32'(w), 0);
    csr(1, 32'h400, 32'h5, 4'hF, 0, 0, w);
    check("clk_en_write", 32'(clk_en), 32'h5);
    csr(1, 32'h400, 32'hF, 4'h0, 0, 0, w);
    check("clk_en_nostrb", 32'(clk_en), 32'h5);
    csr(0, 32'h400, 0, 4'hF, 0, 32'h5, w);
    csr(0, 32'h410, 0, 4'hF, 0, 32'h0, w);

    eng_acc(0, 32'h200, 0, 2, 3, 32'hCAFE_0002);
    eng_acc(0, 32'h000, 0, 0, 0, 32'h1234_0000);
    eng_acc(1, 32'h304, 32'hDEAD_BEEF, 3, 1, 32'h0);

    evt_pulse(8'h02);
    check("evt_set", 32'(evt_out), 32'h2);
    csr(1, 32'h408, 32'h2, 4'hF, 8'h02, 0, w);
    check("evt_set_wins", 32'(evt_out), 32'h2);
    csr(1, 32'h408, 32'h2, 4'hF, 8'h00, 0, w);
    check("evt_w1c", 32'(evt_out), 32'h0);
    evt_pulse(8'h04);
    check("evt_gated", 32'(evt_out), 32'h0);
    evt_pulse(8'h10);
    check("evt_eng2", 32'(evt_out), 32'h1);
    csr(0, 32'h408, 0, 4'hF, 0, 32'h1, w);
    csr(1, 32'h408, 32'h3, 4'hF, 0, 0, w);
    check("evt_clear_all", 32'(evt_out), 32'h0);

    // redirect during drain: 3 requested, then 1
    tcdm_reads(1);
    csr(1, 32'h404, 32'h3, 4'hF, 0, 0, w);
    check("a_hold_drain", 32'(t_hold), 1);
    csr(1, 32'h404, 32'h1, 4'hF, 0, 0, w);
    check("a_hold_redirect", 32'(t_hold), 1);
    check("a_mux_old", 32'(mux_sel), 0);
    rvalid_pulse();
    check("a_hold_r1", 32'(t_hold), 1);
    @(posedge clk); #1;
    check("a_hold_switch", 32'(t_hold), 1);
    check("a_mux_switch", 32'(mux_sel), 0);
    @(posedge clk); #1;
    check("a_hold_done", 32'(t_hold), 0);
    check("a_mux_new", 32'(mux_sel), 1);

    // three reads in flight, switch to 3
    tcdm_reads(3);
    csr(1, 32'h404, 32'h3, 4'hF, 0, 0, w);
    check("b_hold0", 32'(t_hold), 1);
    rvalid_pulse();
    check("b_hold1", 32'(t_hold), 1);
    rvalid_pulse();
    check("b_hold2", 32'(t_hold), 1);
    check("b_mux_keep", 32'(mux_sel), 1);
    rvalid_pulse();
    check("b_hold3", 32'(t_hold), 1);
    @(posedge clk); #1;
    check("b_hold_switch", 32'(t_hold), 1);
    check("b_mux_switch", 32'(mux_sel), 1);
    @(posedge clk); #1;
    check("b_hold_done", 32'(t_hold), 0);
    check("b_mux_new", 32'(mux_sel), 3);

    csr(1, 32'h404, 32'h7, 4'hF, 0, 0, w);
    check("c_hold_ignored", 32'(t_hold), 0);
    csr(0, 32'h40C, 0, 4'hF, 0, 32'h3, w);
    csr(0, 32'h404, 0, 4'hF, 0, 32'h3, w);

    // abort by rewriting the current select
    tcdm_reads(1);
    csr(1, 32'h404, 32'h0, 4'hF, 0, 0, w);
    check("d_hold_drain", 32'(t_hold), 1);
    csr(0, 32'h40C, 0, 4'hF, 0, 32'hF, w);
    csr(1, 32'h404, 32'h3, 4'hF, 0, 0, w);
    check("d_hold_abort", 32'(t_hold), 0);
    check("d_mux_kept", 32'(mux_sel), 3);
    rvalid_pulse();

    // async reset during drain with an engine read outstanding
    tcdm_reads(1);
    csr(1, 32'h404, 32'h1, 4'hF, 0, 0, w);
    @(posedge clk); #1;
    q_valid = 1'b1; q_addr = 32'h100; q_write = 1'b0; h_gnt = 4'b0010;
    @(posedge clk); #1;
    q_valid = 1'b0; h_gnt = '0;
    check("e_mux_before", 32'(mux_sel), 3);
    check("e_hold_before", 32'(t_hold), 1);
    #2 rst_ni = 1'b0;
    #1;
    check("e_rst_mux", 32'(mux_sel), 0);
    check("e_rst_hold", 32'(t_hold), 0);
    check("e_rst_clk_en", 32'(clk_en), 0);
    check("e_rst_p_valid", 32'(p_valid), 0);
    @(negedge clk);
    @(posedge clk); #1 rst_ni = 1'b1;
    csr(0, 32'h40C, 0, 4'hF, 0, 32'h0, w);
    check("e_not_pending", 32'(w), 0);
    csr(0, 32'h404, 0, 4'hF, 0, 32'h0, w);

    repeat (5) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
